// File: rtl/audio_stream_sequencer_pkg.sv
// Shared types and defaults for the audio stream sequencer: sample and gain
// types, the unity gain constant and the sequencer state encoding.
package audio_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_GAIN_W    = 9;
  localparam int DEF_RAMP_STEP = 16;
  localparam int DEF_CNT_W     = 16;

  typedef logic signed [DEF_DATA_W-1:0] sample_t;
  typedef logic        [DEF_GAIN_W-1:0] gain_t;

  localparam int GAIN_UNITY = 256;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCALE,
    S_WRITE
  } state_t;

endpackage

// File: rtl/audio_gain_scale.sv
// Combinational scaler for one audio channel: multiplies a signed sample by an
// unsigned gain whose unity value is 2**(GAIN_W-1), then floors by that unity.
module audio_gain_scale #(
  parameter int DATA_W = 32,
  parameter int GAIN_W = 9
) (
  input  logic signed [DATA_W-1:0] i_sample,
  input  logic        [GAIN_W-1:0] i_gain,
  output logic signed [DATA_W-1:0] o_result
);

  localparam int PROD_W = DATA_W + GAIN_W;

  logic signed [PROD_W-1:0] w_product;

  // Full-width product with the gain zero-extended so it stays non-negative;
  // the arithmetic shift rounds toward minus infinity, and since gain never
  // exceeds unity the truncated result always fits in DATA_W bits.
  always_comb begin
    w_product = PROD_W'(i_sample) * PROD_W'($signed({1'b0, i_gain}));
    o_result  = DATA_W'(w_product >>> (GAIN_W - 1));
  end

endmodule

// File: rtl/audio_stream_sequencer.sv
// Moves one stereo sample at a time from the codec input FIFO to the codec
// output FIFO: pop, scale by the soft-mute gain, push. The gain ramps toward
// zero or unity by a fixed step each time a sample is accepted for output.
module audio_stream_sequencer
  import audio_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int GAIN_W    = DEF_GAIN_W,
  parameter int RAMP_STEP = DEF_RAMP_STEP,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                     CLOCK_50,
  input  logic                     resetn,
  input  logic                     mute,
  input  logic                     audio_in_available,
  input  logic signed [DATA_W-1:0] audio_in_L,
  input  logic signed [DATA_W-1:0] audio_in_R,
  output logic                     read_audio_in,
  input  logic                     audio_out_allowed,
  output logic                     write_audio_out,
  output logic signed [DATA_W-1:0] audio_out_L,
  output logic signed [DATA_W-1:0] audio_out_R,
  output logic        [GAIN_W-1:0] gain,
  output logic        [CNT_W-1:0]  sample_count,
  output logic                     busy
);

  localparam logic [GAIN_W-1:0] L_UNITY = GAIN_W'(1 << (GAIN_W - 1));
  localparam logic [GAIN_W-1:0] L_STEP  = GAIN_W'(RAMP_STEP);

  state_t                   r_state;
  state_t                   w_next_state;
  logic                     w_latch;
  logic                     w_scale;
  logic                     w_accept;

  logic signed [DATA_W-1:0] r_in_l;
  logic signed [DATA_W-1:0] r_in_r;
  logic signed [DATA_W-1:0] r_out_l;
  logic signed [DATA_W-1:0] r_out_r;
  logic signed [DATA_W-1:0] w_scaled_l;
  logic signed [DATA_W-1:0] w_scaled_r;
  logic        [GAIN_W-1:0] r_gain;
  logic        [GAIN_W-1:0] w_target;
  logic        [GAIN_W-1:0] w_gain_next;
  logic        [CNT_W-1:0]  r_count;
  logic                     r_read;
  logic                     r_write;

  // Both channels share the same gain; the results are registered in S_SCALE.
  audio_gain_scale #(.DATA_W(DATA_W), .GAIN_W(GAIN_W)) u_scale_l (
    .i_sample (r_in_l),
    .i_gain   (r_gain),
    .o_result (w_scaled_l)
  );

  audio_gain_scale #(.DATA_W(DATA_W), .GAIN_W(GAIN_W)) u_scale_r (
    .i_sample (r_in_r),
    .i_gain   (r_gain),
    .o_result (w_scaled_r)
  );

  // State register; an asynchronous reset abandons any in-flight sample.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state decode: pop on availability, one scaling cycle, then wait for space.
  always_comb begin
    w_next_state = r_state;
    w_latch      = 1'b0;
    w_scale      = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (audio_in_available) begin
          w_latch      = 1'b1;
          w_next_state = S_SCALE;
        end
      end
      S_SCALE: begin
        w_scale      = 1'b1;
        w_next_state = S_WRITE;
      end
      S_WRITE: begin
        if (audio_out_allowed) begin
          w_accept     = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Gain moves one step toward the mute target, clamping so it never overshoots.
  always_comb begin
    w_target    = mute ? '0 : L_UNITY;
    w_gain_next = r_gain;
    if (r_gain > w_target) begin
      w_gain_next = ((r_gain - w_target) > L_STEP) ? (r_gain - L_STEP) : w_target;
    end else if (r_gain < w_target) begin
      w_gain_next = ((w_target - r_gain) > L_STEP) ? (r_gain + L_STEP) : w_target;
    end
  end

  // Datapath and strobes: each strobe is the registered copy of a one-cycle
  // FSM event, so it lasts exactly one cycle and the two never coincide.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_in_l  <= '0;
      r_in_r  <= '0;
      r_out_l <= '0;
      r_out_r <= '0;
      r_gain  <= L_UNITY;
      r_count <= '0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
    end else begin
      r_read  <= w_latch;
      r_write <= w_accept;
      if (w_latch) begin
        r_in_l <= audio_in_L;
        r_in_r <= audio_in_R;
      end
      if (w_scale) begin
        r_out_l <= w_scaled_l;
        r_out_r <= w_scaled_r;
      end
      if (w_accept) begin
        r_count <= r_count + 1'b1;
        r_gain  <= w_gain_next;
      end
    end
  end

  assign read_audio_in   = r_read;
  assign write_audio_out = r_write;
  assign audio_out_L     = r_out_l;
  assign audio_out_R     = r_out_r;
  assign gain            = r_gain;
  assign sample_count    = r_count;
  assign busy            = (r_state != S_IDLE);

endmodule

// File: doc/audio_stream_sequencer.md
Name: audio_stream_sequencer

Overview:
Sequences the codec FIFO handshake for one stereo sample at a time: read a sample, scale it, then write it out.
- Replaces the per-cycle passthrough with a registered FSM. Every read pulse is paired with exactly one write pulse.
- Applies a click-free soft mute: gain ramps toward 0 or unity once per written sample.
- Sits between the audio codec core's FIFO ports and the top-level switches.

Parameters:
- DATA_W, 32, sample width per channel (signed).
- GAIN_W, 9, unsigned gain width; unity = 2**(GAIN_W-1) = 256.
- RAMP_STEP, 16, gain change applied per written sample while ramping.
- CNT_W, 16, width of the written-sample counter.

Ports:
- CLOCK_50  in  1  system clock; all state updates on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- mute  in  1  mute request (SW[0]); level-sensitive.
- audio_in_available  in  1  codec has a stereo sample ready.
- audio_in_L  in  DATA_W  left input sample, signed.
- audio_in_R  in  DATA_W  right input sample, signed.
- read_audio_in  out  1  one-cycle pop strobe to the codec input FIFO.
- audio_out_allowed  in  1  codec output FIFO has space.
- write_audio_out  out  1  one-cycle push strobe to the codec output FIFO.
- audio_out_L  out  DATA_W  scaled left sample, signed.
- audio_out_R  out  DATA_W  scaled right sample, signed.
- gain  out  GAIN_W  current gain (0..256).
- sample_count  out  CNT_W  number of samples written; wraps.
- busy  out  1  high whenever state is not S_IDLE.

Behaviour:
- Reset (resetn low, asynchronous): state S_IDLE; gain 256; audio_out_L/R, sample_count, read_audio_in, write_audio_out and busy all 0.
  - Reset mid-sample discards the in-flight sample; no write pulse is issued for it.
  - Release is synchronous to CLOCK_50.
- S_IDLE: on the first edge where audio_in_available=1:
  - latch audio_in_L/R;
  - read_audio_in=1 for exactly the following cycle;
  - go to S_SCALE.
  - Otherwise stay in S_IDLE with both strobes 0.
- S_SCALE (one cycle), for each channel:
  - product = sample * {0,gain}, full 41-bit signed;
  - result = product >>> (GAIN_W-1), truncated to DATA_W bits;
  - register the result into audio_out_L/R; go to S_WRITE.
  - No overflow is possible because gain ≤ 256.
  - Rounding is floor (arithmetic shift).
- S_WRITE: audio_out_L/R are held stable.
  - On an edge with audio_out_allowed=1: write_audio_out=1 for exactly the next cycle, sample_count++ (wrapping), gain steps once, go to S_IDLE.
  - While audio_out_allowed=0: stay in S_WRITE indefinitely; audio_in_available is ignored and no further read is issued.
- Gain step, at write acceptance only; target = mute ? 0 : 256:
  - if gain > target: gain = max(gain - RAMP_STEP, target);
  - if gain < target: gain = min(gain + RAMP_STEP, target).
  - The mute level is sampled on the write-accept edge only. Toggling mute between samples affects the next step, never the sample already scaled.
- Latency: audio_in_available seen at edge E0 gives:
  - read_audio_in high E0..E1;
  - outputs valid at E1;
  - earliest write_audio_out high E2..E3.
  - Minimum period is 3 cycles per sample.
- Strobes are registered. read_audio_in and write_audio_out are never high in the same cycle, and neither is ever high for 2 consecutive cycles.
- Handshake inputs that drop mid-sequence do not abort it, with one exception: a low audio_out_allowed stalls S_WRITE.

Decomposition:
- Package audio_pkg: sample_t (signed DATA_W), gain_t (GAIN_W), GAIN_UNITY = 256, and the state enum {S_IDLE, S_SCALE, S_WRITE}.
- One sub-module, audio_gain_scale: combinational signed multiply-and-shift for one channel. It is instantiated twice (L and R); the parent registers the results.

Test Plan:
- Passthrough: mute=0, L=1000, R=-1000, both handshakes high → read pulse 1 cycle, then write pulse; out L=1000, R=-1000; sample_count=1; gain=256.
- Soft mute ramp: mute=1, stream L=1000, R=-1000 continuously → gain after each write 240, 224, …, 0 (16 samples).
  - Second sample outputs L=937, R=-938.
  - All samples after gain reaches 0 output 0/0.
- Unmute ramp: from gain 0, mute=0 → gain climbs 16/sample back to 256; outputs return to exact passthrough.
- Write stall: audio_out_allowed=0 for 20 cycles in S_WRITE while audio_in_available=1 → no read and no write pulse; outputs held; busy=1. Raising allowed → a single write pulse, then a normal next read.
- Extremes: gain=256 with L=0x7FFFFFFF, R=0x80000000 → unchanged; at gain 128 → 0x3FFFFFFF / 0xC0000000.
- Reset mid-sample: assert resetn=0 in S_SCALE → all outputs 0, no write pulse; sample_count wraps 0xFFFF→0 after 65536 writes.
